// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared constants and state encoding for the program loader
// Purpose: state encoding, byte geometry of an instruction word.
// Build option: LOADER_CHECKSUM_EN enables the CHECK state in program_loader.
package program_loader_pkg;

    localparam int BYTE_WIDTH     = 8;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_COLLECT = S_COLLECT,
        ST_WRITE   = S_WRITE,
        ST_CHECK   = S_CHECK,
        ST_DONE    = S_DONE
    } state_t;

endpackage

// File: rtl/program_loader_word_packer.sv
// rtl/program_loader_word_packer.sv - little-endian byte-to-word packer
// Purpose: inserts byte k of a word into bits [8k+7:8k] and flags the fourth byte.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clear           restart at byte 0 (word contents are left as they are)
//   load            accept byte_data this cycle
//   byte_data       incoming byte
//   word            packed word register
//   word_full       load of the last byte of a word is happening this cycle
module program_loader_word_packer
    import program_loader_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 load,
    input  logic [BYTE_WIDTH-1:0]                byte_data,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] word,
    output logic                                 word_full
);

    localparam int IW = $clog2(BYTES_PER_WORD);

    logic [IW-1:0] index;

    assign word_full = load && (index == IW'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index <= '0;
            word  <= '0;
        end else if (clear) begin
            index <= '0;
        end else if (load) begin
            word[index*BYTE_WIDTH +: BYTE_WIDTH] <= byte_data;
            // Index wraps naturally from the last byte back to 0.
            index <= index + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a byte image into instruction memory while holding the core
// Purpose: packs bytes into 32-bit words and writes them to consecutive word addresses from 0.
// Build option: LOADER_CHECKSUM_EN adds a trailing checksum byte and the error flag.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, word_count          load request (IDLE only) and word count, clamped to memory_depth
//   byte_valid, byte_data      byte stream in; byte_ready is the accept strobe
//   mem_we, mem_address, mem_wdata  one-cycle word write to program memory
//   busy, cpu_hold             load in progress (core held)
//   done                       one-cycle completion pulse
//   error                      checksum mismatch, held until the next start
module program_loader
    import program_loader_pkg::*;
#(
    parameter int memory_depth = 128,
    parameter int data_width   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(memory_depth):0] word_count,
    input  logic                          byte_valid,
    input  logic [BYTE_WIDTH-1:0]         byte_data,
    output logic                          byte_ready,
    output logic                          mem_we,
    output logic [data_width-1:0]         mem_address,
    output logic [data_width-1:0]         mem_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          cpu_hold,
    output logic                          error
);

    localparam int CW = $clog2(memory_depth) + 1;

    state_t                              state, state_next;
    logic [CW-1:0]                       count_q, count_clamped;
    logic                                handshake, start_load, word_full, last_word;
    logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] packed_word;

    assign count_clamped = (word_count > CW'(memory_depth)) ? CW'(memory_depth) : word_count;
    assign start_load    = (state == ST_IDLE) && start;
    assign handshake     = byte_valid && byte_ready;
    // mem_address counts words already written, so this WRITE is the last one
    // when address + 1 reaches the latched count.
    assign last_word     = (mem_address + data_width'(1)) == data_width'(count_q);

`ifdef LOADER_CHECKSUM_EN
    assign byte_ready = (state == ST_COLLECT) || (state == ST_CHECK);
`else
    assign byte_ready = (state == ST_COLLECT);
`endif

    program_loader_word_packer word_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_load),
        .load      (handshake && (state == ST_COLLECT)),
        .byte_data (byte_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    assign mem_wdata = data_width'(packed_word);
    assign cpu_hold  = busy;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = (count_clamped == '0) ? ST_DONE : ST_COLLECT;
            end
            ST_COLLECT: begin
                if (word_full) state_next = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_next = last_word ? ST_CHECK : ST_COLLECT;
`else
                state_next = last_word ? ST_DONE : ST_COLLECT;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (handshake) state_next = ST_DONE;
            end
`endif
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            count_q     <= '0;
            mem_address <= '0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state  <= state_next;
            mem_we <= (state_next == ST_WRITE);
            done   <= (state_next == ST_DONE);
            busy   <= (state_next != ST_IDLE);
            if (start_load) begin
                count_q     <= count_clamped;
                mem_address <= '0;
            end else if (state == ST_WRITE) begin
                mem_address <= mem_address + data_width'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum   <= '0;
            error <= 1'b0;
        end else if (start_load) begin
            sum   <= '0;
            error <= 1'b0;
        end else if (handshake && (state == ST_COLLECT)) begin
            sum <= sum + byte_data;
        end else if (handshake && (state == ST_CHECK)) begin
            error <= (byte_data != sum);
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program image into the instruction program memory from an external byte stream, so the single-cycle RISC-V core can be reloaded without re-synthesising the memory init file. It accepts bytes over a valid/ready handshake, packs them little-endian into 32-bit instruction words, and issues one-cycle word writes at consecutive word addresses starting at 0. While loading it holds the processor in reset.

## Interface
- memory_depth, 128, number of instruction words in program memory.
- data_width, 32, instruction word width; fixed at 4 bytes.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces the idle state.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- word_count  in  $clog2(memory_depth)+1  words to load; latched on start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  next image byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  program-memory write strobe, one cycle per word.
- mem_address  out  data_width  word-indexed write address.
- mem_wdata  out  data_width  packed instruction word.
- busy  out  1  high from the cycle after start until DONE is left.
- done  out  1  one-cycle pulse when the load completes.
- cpu_hold  out  1  equals busy; drives the core's reset/hold.
- error  out  1  checksum mismatch flag (see Configuration).

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (macro only), DONE.
- IDLE: byte_ready=0. On start, latch word_count clamped to memory_depth, clear the address and byte index, clear error. Go to DONE if the latched count is 0, otherwise go to COLLECT.
- COLLECT: byte_ready=1. On a handshake (byte_valid && byte_ready), place byte k (k=0..3) into mem_wdata[8k+7:8k]. After byte 3, go to WRITE.
- WRITE: byte_ready=0 and mem_we=1 for exactly one cycle, with mem_address and mem_wdata stable.
  - The next edge increments mem_address.
  - If the number of written words equals the latched count, go to CHECK (macro) or DONE. Otherwise go to COLLECT.
- DONE: done=1 for one cycle, then go to IDLE. mem_address keeps its final value.
- start outside IDLE is ignored.
- byte_valid without byte_ready is held off. Bytes are never dropped or duplicated.
- The address never wraps, because the count is clamped to memory_depth.

## Timing
- Every output is 0 after reset: mem_address=0, mem_wdata=0, error=0.
- Reset asserted mid-load aborts immediately. The memory keeps the words already written.
- All outputs are registered except byte_ready, which is decoded from the state.
- start at edge n gives busy=1 at n+1. With word_count=0, done pulses at n+1.
- Byte 3 accepted at edge m gives mem_we=1 during the cycle after m.
- Minimum rate is 5 cycles per word (4 byte handshakes plus 1 write cycle).
- For N words with no stalls: start at edge 0 gives done high 5N+1 cycles later, plus 1 cycle with the macro.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) of all image bytes is kept.
  - After the last WRITE, CHECK raises byte_ready and accepts one trailing checksum byte.
  - error is set if that byte differs from the sum, and held until the next start.
- LOADER_CHECKSUM_EN undefined: no CHECK state, no trailing byte, error tied to 0.

## Structure
- Shared package holds:
  - state encoding localparams;
  - BYTE_WIDTH=8;
  - BYTES_PER_WORD=4.
- One sub-module, word_packer, holds the byte index counter and the little-endian shift/insert into a 32-bit register. It signals word_full.

## Test plan
- word_count=2, bytes 13 00 00 00 93 00 10 00 with no stalls: writes 0x00000013 to address 0, then 0x00100093 to address 1. done pulses once, 11 cycles after start.
- Random byte_valid gaps (~50% duty): same memory contents and order, one mem_we per word, no extra handshakes.
- word_count=0: done pulses the cycle after start, with no mem_we and no byte_ready.
- word_count=200 with memory_depth=128: exactly 128 writes to addresses 0..127, then done.
- Reset asserted after 5 bytes: all outputs 0 on the same edge, state IDLE, no further writes.
- LOADER_CHECKSUM_EN with one word AA BB CC DD:
  - trailing 0x0E gives error=0;
  - trailing 0x0F gives error=1, held until the next start.
